// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source: cascaded pixel/line counters with registered sync and blanking.
// Optional frame strobe and frame counter ports appear when VGA_FRAME_TICK_EN is defined.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 800,
  parameter int H_SYNC_BEG = 840,
  parameter int H_SYNC_END = 967,
  parameter int H_TOTAL    = 1056,
  parameter int V_VISIBLE  = 600,
  parameter int V_SYNC_BEG = 601,
  parameter int V_SYNC_END = 604,
  parameter int V_TOTAL    = 628
) (
  input  logic        pclk,
  input  logic        reset,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SBEG  = 11'(H_SYNC_BEG);
  localparam logic [10:0] H_SEND  = 11'(H_SYNC_END);
  localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
  localparam logic [10:0] V_SBEG  = 11'(V_SYNC_BEG);
  localparam logic [10:0] V_SEND  = 11'(V_SYNC_END);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_hblnk;
  logic        r_vsync;
  logic        r_vblnk;

  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_h_wrap;

  assign w_h_wrap = (r_hcount == H_LAST);

  // NOTE: always_comb assigns every output unconditionally so no latch can be inferred.
  always_comb begin
    w_h_next = r_hcount + 11'd1;
    w_v_next = r_vcount;
    if (w_h_wrap) begin
      w_h_next = '0;
      w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + 11'd1;
    end
  end

  // Strobes are decoded from the next counts so they line up with the registered counts.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_vsync  <= 1'b0;
      r_vblnk  <= 1'b0;
    end else begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_hsync  <= (w_h_next >= H_SBEG) && (w_h_next <= H_SEND);
      r_hblnk  <= (w_h_next >= H_VIS);
      r_vsync  <= (w_v_next >= V_SBEG) && (w_v_next <= V_SEND);
      r_vblnk  <= (w_v_next >= V_VIS);
    end
  end

  assign hcount_out = r_hcount;
  assign vcount_out = r_vcount;
  assign hsync_out  = r_hsync;
  assign hblnk_out  = r_hblnk;
  assign vsync_out  = r_vsync;
  assign vblnk_out  = r_vblnk;

`ifdef VGA_FRAME_TICK_EN
  logic        r_frame_tick;
  logic [15:0] r_frame_cnt;
  logic        w_tick_next;

  assign w_tick_next = (w_h_next == '0) && (w_v_next == V_VIS);

  // Counter wraps naturally at 16 bits; it holds between ticks.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_tick <= w_tick_next;
      if (w_tick_next) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 instance plus a small-raster instance for whole frames,
// both checked every cycle against an arithmetic model driven by cycles-since-reset.
module tb_vga_timing_gen;

  localparam int SH_VIS = 16, SH_SB = 18, SH_SE = 21, SH_TOT = 26;
  localparam int SV_VIS = 10, SV_SB = 11, SV_SE = 12, SV_TOT = 14;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [10:0] hc_a, vc_a, hc_b, vc_b;
  logic hs_a, hb_a, vs_a, vb_a, hs_b, hb_b, vs_b, vb_b;
`ifdef VGA_FRAME_TICK_EN
  logic        ft_a, ft_b;
  logic [15:0] fc_a, fc_b;
`endif

  vga_timing_gen dut_a (
    .pclk(clk), .reset(rst_a),
    .hcount_out(hc_a), .hsync_out(hs_a), .hblnk_out(hb_a),
    .vcount_out(vc_a), .vsync_out(vs_a), .vblnk_out(vb_a)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft_a), .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_SYNC_BEG(SH_SB), .H_SYNC_END(SH_SE), .H_TOTAL(SH_TOT),
    .V_VISIBLE(SV_VIS), .V_SYNC_BEG(SV_SB), .V_SYNC_END(SV_SE), .V_TOTAL(SV_TOT)
  ) dut_b (
    .pclk(clk), .reset(rst_b),
    .hcount_out(hc_b), .hsync_out(hs_b), .hblnk_out(hb_b),
    .vcount_out(vc_b), .vsync_out(vs_b), .vblnk_out(vb_b)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft_b), .frame_cnt(fc_b)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Model state: pixel clocks elapsed since the last sampled reset.
  int          na = 0;
  int          nb = 0;
  bit          live = 1'b0;
  logic [15:0] fc_exp_a = '0;
  logic [15:0] fc_exp_b = '0;

  function automatic bit is_tick(input int n, input int ht, input int vt, input int vv);
    return (n % ht == 0) && ((n / ht) % vt == vv);
  endfunction

  always @(posedge clk) begin
    na   <= rst_a ? 0 : na + 1;
    nb   <= rst_b ? 0 : nb + 1;
    live <= 1'b1;
    if (rst_a) fc_exp_a <= '0;
    else if (is_tick(na + 1, 1056, 628, 600)) fc_exp_a <= fc_exp_a + 16'd1;
    if (rst_b) fc_exp_b <= '0;
    else if (is_tick(nb + 1, SH_TOT, SV_TOT, SV_VIS)) fc_exp_b <= fc_exp_b + 16'd1;
  end

  task automatic cmp(input string tag, input int n,
                     input int ht, input int hv, input int hsb, input int hse,
                     input int vt, input int vv, input int vsb, input int vse,
                     input logic [10:0] hc, input logic [10:0] vc,
                     input logic hs, input logic hb, input logic vs, input logic vb);
    int h, v;
    h = n % ht;
    v = (n / ht) % vt;
    check({tag, ".hcount"}, hc, h);
    check({tag, ".vcount"}, vc, v);
    check({tag, ".hsync"},  hs, (h >= hsb && h <= hse));
    check({tag, ".hblnk"},  hb, (h >= hv));
    check({tag, ".vsync"},  vs, (v >= vsb && v <= vse));
    check({tag, ".vblnk"},  vb, (v >= vv));
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp("a", na, 1056, 800, 840, 967, 628, 600, 601, 604, hc_a, vc_a, hs_a, hb_a, vs_a, vb_a);
      cmp("b", nb, SH_TOT, SH_VIS, SH_SB, SH_SE, SV_TOT, SV_VIS, SV_SB, SV_SE,
          hc_b, vc_b, hs_b, hb_b, vs_b, vb_b);
`ifdef VGA_FRAME_TICK_EN
      check("a.frame_tick", ft_a, is_tick(na, 1056, 628, 600));
      check("a.frame_cnt",  fc_a, fc_exp_a);
      check("b.frame_tick", ft_b, is_tick(nb, SH_TOT, SV_TOT, SV_VIS));
      check("b.frame_cnt",  fc_b, fc_exp_b);
`endif
    end
  end

  // Wait (bounded) until the small instance's model sits at a given raster position.
  task automatic wait_b_at(input int h, input int v, input int budget, input string name);
    int left;
    left = budget;
    while (!((nb % SH_TOT == h) && ((nb / SH_TOT) % SV_TOT == v)) && left > 0) begin
      @(negedge clk);
      left--;
    end
    if (left == 0) check({name, ".timeout"}, 0, 1);
  endtask

  initial begin
    int hs_cnt, hb_cnt;

    repeat (5) begin
      @(negedge clk);
      check("rst.hcount", hc_a, 0);
      check("rst.vcount", vc_a, 0);
      check("rst.strobes", {hs_a, hb_a, vs_a, vb_a}, 0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("first.hcount", hc_a, 1);
    check("first.vcount", vc_a, 0);

    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 1; i < 1056; i++) begin
      hs_cnt += int'(hs_a);
      hb_cnt += int'(hb_a);
      if (i == 840)  check("line.hsync_at_840", hs_a, 1);
      if (i == 968)  check("line.hsync_at_968", hs_a, 0);
      if (i == 799)  check("line.hblnk_at_799", hb_a, 0);
      if (i == 1055) check("line.hcount_last", hc_a, 1055);
      @(negedge clk);
    end
    check("line.hsync_cycles", hs_cnt, 128);
    check("line.hblnk_cycles", hb_cnt, 256);
    check("wrap.hcount", hc_a, 0);
    check("wrap.vcount", vc_a, 1);

    // Mid-frame reset on the small raster.
    wait_b_at(12, 7, 2 * S_FRAME, "midreset");
    check("midreset.pre_hcount", hc_b, 12);
    check("midreset.pre_vcount", vc_b, 7);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("midreset.hcount", hc_b, 0);
    check("midreset.vcount", vc_b, 0);
    check("midreset.strobes", {hs_b, hb_b, vs_b, vb_b}, 0);
    @(negedge clk);
    check("midreset.resume", hc_b, 1);

    wait_b_at(0, SV_VIS, 2 * S_FRAME, "vblank");
    check("vblank.vcount", vc_b, 10);
    check("vblank.vblnk", vb_b, 1);
    check("vblank.vsync", vs_b, 0);
`ifdef VGA_FRAME_TICK_EN
    check("vblank.frame_tick", ft_b, 1);
    check("vblank.frame_cnt", fc_b, 1);
`endif
    repeat (SH_TOT) @(negedge clk);
    check("vsync.vcount", vc_b, 11);
    check("vsync.vsync", vs_b, 1);

`ifdef VGA_FRAME_TICK_EN
    #2;
    force dut_b.r_frame_cnt = 16'hFFFF;
    fc_exp_b = 16'hFFFF;
    #1;
    release dut_b.r_frame_cnt;
    wait_b_at(0, SV_VIS, 2 * S_FRAME, "fcwrap");
    check("fcwrap.frame_cnt", fc_b, 0);
`endif

    // Random run lengths with occasional resets of random length on both instances.
    repeat (30) begin
      repeat ($urandom_range(1, 500)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        rst_b = 1'b1;
        if ($urandom_range(0, 3) == 0) rst_a = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
    end
    repeat (3 * S_FRAME) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
